alu_cmd_sequencer: RTL

Clocked initiator for the combinational ALU (`a_in`/`b_in`/`command_in`/`oe` → `d_out`). It takes operation requests on a valid/ready port and drives the operands and command onto the ALU. It waits a programmable settle time, captures `d_out`, and returns the result on a second valid/ready port. It sits between the datapath controller and the ALU instance. Divide-by-zero is trapped locally and never reaches the ALU.

---
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Clocked initiator for a combinational ALU: accepts requests, holds operands for a
// programmable settle time, captures d_out and returns it; traps divide-by-zero locally.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  DIV_CMD       = 4'b0101
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  input  logic [3:0]  req_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_dout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic        rsp_err,
  output logic [15:0] op_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        req_ready_reg, req_ready_next;
  logic [7:0]  alu_a_reg, alu_a_next;
  logic [7:0]  alu_b_reg, alu_b_next;
  logic [3:0]  alu_cmd_reg, alu_cmd_next;
  logic        alu_oe_reg, alu_oe_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [15:0] rsp_data_reg, rsp_data_next;
  logic [3:0]  rsp_cmd_reg, rsp_cmd_next;
  logic        rsp_err_reg, rsp_err_next;
  logic [15:0] op_count_reg, op_count_next;
  logic [7:0]  err_count_reg, err_count_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_cmd_reg   <= '0;
      alu_oe_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_cmd_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      op_count_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      req_ready_reg <= req_ready_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_cmd_reg   <= alu_cmd_next;
      alu_oe_reg    <= alu_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_cmd_reg   <= rsp_cmd_next;
      rsp_err_reg   <= rsp_err_next;
      op_count_reg  <= op_count_next;
      err_count_reg <= err_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    req_ready_next = req_ready_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_cmd_next   = alu_cmd_reg;
    alu_oe_next    = alu_oe_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_cmd_next   = rsp_cmd_reg;
    rsp_err_next   = rsp_err_reg;
    op_count_next  = op_count_reg;
    err_count_next = err_count_reg;

    case (state_reg)
      IDLE: begin
        // req_ready comes up on the first edge after reset release
        req_ready_next = 1'b1;
        if (req_valid && req_ready_reg) begin
          req_ready_next = 1'b0;
          if (req_cmd == DIV_CMD && req_b == 8'h00) begin
            // Trapped divide-by-zero: respond directly, ALU stays untouched
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = 16'h0000;
            rsp_err_next   = 1'b1;
            rsp_cmd_next   = req_cmd;
            if (err_count_reg != 8'hFF) err_count_next = err_count_reg + 8'd1;
          end else begin
            state_next   = DRIVE;
            alu_a_next   = req_a;
            alu_b_next   = req_b;
            alu_cmd_next = req_cmd;
            alu_oe_next  = 1'b1;
            cnt_next     = SETTLE_LOAD;
          end
        end
      end
      DRIVE: begin
        if (cnt_reg == 4'd0) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = alu_dout;
          rsp_cmd_next   = alu_cmd_reg;
          rsp_err_next   = 1'b0;
          alu_oe_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
          op_count_next  = op_count_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = req_ready_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_cmd   = alu_cmd_reg;
  assign alu_oe    = alu_oe_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_cmd   = rsp_cmd_reg;
  assign rsp_err   = rsp_err_reg;
  assign op_count  = op_count_reg;
  assign err_count = err_count_reg;

endmodule
